// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the RV32 fetch stage.
// The NOP word, the fetch FSM encoding and the PC legality check live here.
package instruction_fetch_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_t;

    // A fetch address is legal when word aligned and inside the instruction memory.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [32:0] limit);
        return (pc[1:0] == 2'b00) && ({1'b0, pc} < limit);
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_sel.sv
// Next-PC priority mux for the fetch stage plus the legality check on the chosen PC.
// Purely combinational; the top level owns every register.
module if_pc_sel
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024
) (
    input  if_state_t   state,
    input  logic [31:0] pc_q,
    input  logic        ex_br_vld,
    input  logic [31:0] ex_br_addr,
    input  logic        id_jmp_vld,
    input  logic [31:0] id_imm,
    input  logic        id_nop,
    output logic [31:0] pc_next,
    output logic        fault_next,
    output logic        redirect
);

    localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

    always_comb begin
        pc_next    = pc_q;
        fault_next = 1'b0;
        redirect   = 1'b0;
        case (state)
            IF_BOOT: pc_next = RESET_PC;
            IF_RUN: begin
                // EX branch outranks the decode jump, which outranks the stall.
                if (ex_br_vld) begin
                    pc_next  = ex_br_addr;
                    redirect = 1'b1;
                end else if (id_jmp_vld) begin
                    pc_next  = pc_q + id_imm;
                    redirect = 1'b1;
                end else if (id_nop) begin
                    pc_next = pc_q;
                end else begin
                    pc_next = pc_q + 32'd4;
                end
                // Running off the top of memory is a fault, never a wrap.
                fault_next = !pc_legal(pc_next, PC_LIMIT);
            end
            default: pc_next = pc_q;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// RV32 fetch stage: owns the PC, addresses the synchronous instruction memory and
// presents one instruction per cycle to decode; halts stickily on an illegal target.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          AW         = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_data,
    output logic [31:0]   IF_inst,
    output logic [31:0]   IF_pc,
    output logic          IF_vld,
    input  logic          ID_jmp_vld,
    input  logic [31:0]   ID_imm,
    input  logic          ID_nop,
    input  logic          EX_br_vld,
    input  logic [31:0]   EX_br_addr,
    output logic          IF_fault,
    output logic [31:0]   IF_fetch_cnt,
    output if_state_t     state_dbg
);

    // IF_vld qualifies IF_inst/IF_pc every cycle; there is no ready. Decode
    // back-pressures only through ID_nop, which makes the same word reappear next cycle.

    if_state_t   state, state_next;
    logic [31:0] pc_q, pc_next, cnt_q;
    logic        fault_q, fault_next, redirect;

    if_pc_sel #(
        .RESET_PC  (RESET_PC),
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_pc_sel (
        .state     (state),
        .pc_q      (pc_q),
        .ex_br_vld (EX_br_vld),
        .ex_br_addr(EX_br_addr),
        .id_jmp_vld(ID_jmp_vld),
        .id_imm    (ID_imm),
        .id_nop    (ID_nop),
        .pc_next   (pc_next),
        .fault_next(fault_next),
        .redirect  (redirect)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IF_BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IF_BOOT: state_next = IF_RUN;
            IF_RUN:  if (fault_next) state_next = IF_HALT;
            IF_HALT: state_next = IF_HALT;
            default: state_next = IF_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            // On a fault pc_q keeps the last good PC for post-mortem.
            if (fault_next) fault_q <= 1'b1;
            else            pc_q    <= pc_next;
            if (state == IF_RUN && (!ID_nop || redirect)) cnt_q <= cnt_q + 32'd1;
        end
    end

    // Memory address follows pc_next so the word lands on imem_data as pc_q updates.
    always_comb begin
        if (rst)             imem_addr = RESET_PC[AW+1:2];
        else if (fault_next) imem_addr = pc_q[AW+1:2];
        else                 imem_addr = pc_next[AW+1:2];
    end

    always_comb begin
        IF_vld       = (state == IF_RUN);
        IF_inst      = (state == IF_RUN) ? imem_data : INST_NOP;
        IF_pc        = pc_q;
        IF_fault     = fault_q;
        IF_fetch_cnt = cnt_q;
        state_dbg    = state;
    end

endmodule
